// File: rtl/mips_cpu_muldiv_sequencer.sv
// HI/LO unit for the MIPS pipeline: iterative shift-add multiply and restoring divide,
// one iteration per cycle, plus the MTHI/MTLO/MFHI/MFLO moves.
module mips_cpu_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             op_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand, mplier, rem, quo, dvs;
  logic               sign, rsign, is_div;

  logic             accept, last_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, rem_sh, diff;

  assign op_ready  = (state == IDLE);
  assign busy      = !op_ready;
  assign accept    = op_valid && op_ready;
  assign last_step = (cnt == CW'(WIDTH-1));

  // op[1] marks the signed variants, op[0] selects multiply over divide
  assign mag_a = (op[1] && a[WIDTH-1]) ? -a : a;
  assign mag_b = (op[1] && b[WIDTH-1]) ? -b : b;

  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !op[2]) begin
          if (op[0])          state_next = MUL;
          else if (b != '0)   state_next = DIV;
        end
      end
      MUL:     if (last_step) state_next = FIX;
      DIV:     if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi           <= '0;
      lo           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      sign         <= 1'b0;
      rsign        <= 1'b0;
      is_div       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              3'b100: hi <= a;
              3'b101: lo <= a;
              3'b110: begin
                result       <= hi;
                result_valid <= 1'b1;
              end
              3'b111: begin
                result       <= lo;
                result_valid <= 1'b1;
              end
              default: begin
                cnt  <= '0;
                sign <= op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
                if (op[0]) begin
                  mcand  <= mag_a;
                  mplier <= mag_b;
                  acc    <= '0;
                  is_div <= 1'b0;
                end else if (b == '0) begin
                  hi          <= a;
                  lo          <= '1;
                  div_by_zero <= 1'b1;
                end else begin
                  rem    <= '0;
                  quo    <= mag_a;
                  dvs    <= mag_b;
                  rsign  <= op[1] & a[WIDTH-1];
                  is_div <= 1'b1;
                end
              end
            endcase
          end
        end
        MUL: begin
          // carry out of the upper-half add lands in the msb after the shift
          acc    <= {add_sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            lo <= sign  ? -quo : quo;
            hi <= rsign ? -rem : rem;
          end else begin
            {hi, lo} <= sign ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_sequencer.sv
// Directed and randomized checks of the HI/LO sequencer against an arithmetic
// reference model (native 64-bit multiply, divide and remainder).
module tb_mips_cpu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_ready, busy, result_valid, div_by_zero;
  logic [31:0] result, hi, lo;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
  logic        exp_rv, exp_dz;
  int          exp_busy;

  mips_cpu_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .op_ready(op_ready), .busy(busy), .result(result), .result_valid(result_valid),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rise
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic modelOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    exp_rv   = 1'b0;
    exp_dz   = 1'b0;
    exp_busy = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'b000, 3'b010: begin
        if (y == 32'd0) begin
          m_hi   = x;
          m_lo   = 32'hFFFF_FFFF;
          exp_dz = 1'b1;
        end else begin
          exp_busy = 33;
          if (o == 3'b000) begin
            m_lo = x / y;
            m_hi = x % y;
          end else begin
            q = sx / sy;
            r = sx % sy;
            m_lo = q[31:0];
            m_hi = r[31:0];
          end
        end
      end
      3'b001: begin
        p = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = p;
        exp_busy = 33;
      end
      3'b011: begin
        p = sx * sy;
        {m_hi, m_lo} = p;
        exp_busy = 33;
      end
      3'b100: m_hi = x;
      3'b101: m_lo = x;
      3'b110: begin m_res = m_hi; exp_rv = 1'b1; end
      default: begin m_res = m_lo; exp_rv = 1'b1; end
    endcase
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    modelOp(o, x, y);
    applyStimulus(o, x, y);
    checkOutput({tag, "_rv"}, result_valid, exp_rv);
    if (exp_rv) checkOutput({tag, "_result"}, result, m_res);
    checkOutput({tag, "_dz"}, div_by_zero, exp_dz);
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_busy_cycles"}, n, exp_busy);
    checkOutput({tag, "_hi"}, hi, m_hi);
    checkOutput({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    checkOutput("reset_ready", op_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_rv", result_valid, 0);
    checkOutput("reset_dz", div_by_zero, 0);

    runOp("mthi", 3'b100, 32'h1234_5678, 32'd0);
    runOp("mtlo", 3'b101, 32'h9ABC_DEF0, 32'd0);
    runOp("mfhi", 3'b110, 32'd0, 32'd0);
    runOp("mflo", 3'b111, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("rv_single_pulse", result_valid, 0);
    checkOutput("result_held", result, 32'h9ABC_DEF0);

    runOp("mult_neg2x3", 3'b011, 32'hFFFF_FFFE, 32'd3);
    runOp("mfhi_after_mult", 3'b110, 32'd0, 32'd0);
    runOp("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
    runOp("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE);
    runOp("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("divu_big", 3'b000, 32'hFFFF_FFF9, 32'd2);
    runOp("divu_zero", 3'b000, 32'h55, 32'd0);
    checkOutput("divu_zero_ready", op_ready, 1);
    @(negedge clk);
    checkOutput("dz_single_pulse", div_by_zero, 0);
    runOp("mflo_after_dz", 3'b111, 32'd0, 32'd0);

    // MTHI while busy must be ignored; then reset aborts the multiply
    applyStimulus(3'b011, 32'd5, 32'd7);
    op_valid = 1'b1;
    op       = 3'b100;
    a        = 32'hDEAD_BEEF;
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("ignore_ready", op_ready, 0);
    checkOutput("ignore_hi", hi, m_hi);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    checkOutput("abort_ready", op_ready, 1);
    checkOutput("abort_hi", hi, 0);
    checkOutput("abort_lo", lo, 0);
    runOp("mult_5x7", 3'b011, 32'd5, 32'd7);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(1, 9));
      runOp($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv_sequencer.md
# mips_cpu_muldiv_sequencer

Multi-cycle sequencer for the MIPS HI/LO unit. It accepts the 3-bit multiply/divide op code produced by ALU control and runs an iterative shift-add multiplier or restoring divider over WIDTH cycles. It owns the HI and LO registers and serves MTHI/MTLO/MFHI/MFLO. The pipeline stalls on `op_ready` low and takes MFHI/MFLO data from `result`.

## Interface
- WIDTH, 32, operand width; even, ≥4; one iteration per cycle, so WIDTH iterations per MULT/DIV.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- op_valid  in  1  issue strobe from decode
- op  in  3  op code: 000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- op_ready  out  1  high only in IDLE; op accepted on op_valid && op_ready
- busy  out  1  high in MUL, DIV, FIX
- result  out  WIDTH  MFHI/MFLO read data
- result_valid  out  1  one-cycle pulse qualifying `result`
- div_by_zero  out  1  one-cycle pulse on DIV/DIVU with b == 0
- hi, lo  out  WIDTH  architectural HI/LO registers

## Operation
- States: IDLE, MUL, DIV, FIX. `op_ready` = (state == IDLE). `busy` = !op_ready.
- Sampling: a, b and op are sampled only on accept. op_valid while not ready is ignored, and the requester holds it.
- IDLE actions on accept:
  - MTHI: hi <= a. MTLO: lo <= a. State stays IDLE.
  - MFHI/MFLO: result <= hi/lo; result_valid pulses next cycle; state stays IDLE. An MF accepted in the same edge as an MT read returns the pre-MT value.
  - MULT/MULTU: latch |a| and |b|. For signed ops, record sign = a[msb]^b[msb]. Clear the 2·WIDTH accumulator and the counter, then go to MUL.
  - DIV/DIVU with b == 0: hi <= a, lo <= all-ones, div_by_zero pulses, state stays IDLE.
  - DIV/DIVU with b != 0: latch magnitudes. For signed ops, record the quotient sign (a^b) and the remainder sign (a). Go to DIV.
  - For unsigned ops, the magnitudes are the raw operands and the signs are 0.
- MUL step: if multiplier lsb is 1, add multiplicand into the upper half of the accumulator, with carry-out kept. Then shift accumulator and multiplier right by 1.
- DIV step: shift {rem, quo} left by 1 and trial-subtract the divisor from rem. If the result is non-negative, rem <= difference and quo lsb <= 1.
- Counter: increments each step. After the step with counter == WIDTH-1, the state goes to FIX.
- FIX:
  - Multiply: {hi, lo} <= sign ? −product : product, 2·WIDTH-bit two's complement.
  - Divide: lo <= qsign ? −quo : quo; hi <= rsign ? −rem : rem.
  - Then go to IDLE.
- Overflow case: signed most-negative ÷ −1 gives lo = most-negative and hi = 0, by natural wrap. No flag is raised.
- Reset mid-operation: the in-flight op is discarded; state → IDLE and the counter is cleared.

## Timing
- Reset values: state IDLE, op_ready 1, busy 0, hi 0, lo 0, result 0, result_valid 0, div_by_zero 0.
- MULT/DIV accepted at edge T:
  - Steps occupy cycles T+1 … T+WIDTH; FIX occupies T+WIDTH+1.
  - hi/lo are updated at edge T+WIDTH+2, when op_ready returns high.
  - op_ready is low for exactly WIDTH+1 cycles.
- MFHI issued back-to-back after MULT: accepted at T+WIDTH+2; result_valid is high in the following cycle carrying the new hi.
- MT, MF and divide-by-zero complete in one cycle with no busy time, so back-to-back accepts every cycle are legal.
- result holds its last value between pulses. result_valid and div_by_zero are never high for two consecutive cycles from a single op.

## Test plan
- MTHI 0x12345678, MTLO 0x9ABCDEF0, MFHI, MFLO on 4 consecutive cycles → result_valid pulses carry 0x12345678 then 0x9ABCDEF0. hi/lo match.
- MULT a=0xFFFFFFFE, b=3 → op_ready low 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed cases:
  - −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7 ÷ −2 → lo=0xFFFFFFFD, hi=0x00000001.
  - 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU signed-looking operands: 0xFFFFFFF9 ÷ 2 → lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=0x55, b=0 → div_by_zero pulses 1 cycle; hi=0x55, lo=0xFFFFFFFF; op_ready never drops. A following MFLO returns 0xFFFFFFFF.
- Mid-operation reset and busy-ignore:
  - Start MULT 5×7; pulse op_valid with MTHI while busy → ignored, hi unaffected.
  - Assert reset at step 10 → next cycle IDLE, hi=lo=0, op_ready=1.
  - A new MULT 5×7 then yields lo=35, hi=0.
